// File: rtl/cword_mat_mult.sv
// cword_mat_mult: complex matrix multiplier Y_q = H x S_q for every codeword q.
//   H (M x K) is loaded from a row-major element stream and retained across runs
//   and resets; the codebook S_q (K x L per codeword) is a RAM written through
//   cb_*. Each output element takes K cycles (one complex MAC per cycle), is
//   rounded half-up at Q fractional bits and saturated to N bits.
//   All parameters are expected to be >= 2 so every tag field is at least 1 bit wide.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start, reuse_h      begin a run; reuse_h=1 skips the H load
//   h_valid/h_ready     H element stream, h_r/h_i data
//   cb_we/cb_addr       codebook write (q*K*L + k*L + l), cb_r/cb_i data
//   y_valid/y_ready     result stream, y_r/y_i data, y_q/y_row/y_col tags
//   busy, done          not idle / one-cycle end-of-run pulse
//   sat_flag            sticky saturation indicator, cleared by an accepted start
module cword_mat_mult #(
  parameter int unsigned Q  = 8,
  parameter int unsigned N  = 16,
  parameter int unsigned M  = 4,
  parameter int unsigned K  = 4,
  parameter int unsigned L  = 2,
  parameter int unsigned NQ = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         reuse_h,
  input  logic                         h_valid,
  output logic                         h_ready,
  input  logic [N-1:0]                 h_r,
  input  logic [N-1:0]                 h_i,
  input  logic                         cb_we,
  input  logic [$clog2(NQ*K*L)-1:0]    cb_addr,
  input  logic [N-1:0]                 cb_r,
  input  logic [N-1:0]                 cb_i,
  output logic                         y_valid,
  input  logic                         y_ready,
  output logic [N-1:0]                 y_r,
  output logic [N-1:0]                 y_i,
  output logic [$clog2(NQ)-1:0]        y_q,
  output logic [$clog2(M)-1:0]         y_row,
  output logic [$clog2(L)-1:0]         y_col,
  output logic                         busy,
  output logic                         done,
  output logic                         sat_flag
);

  localparam int unsigned AW  = 2 * N + $clog2(K) + 1;
  localparam int unsigned HN  = M * K;
  localparam int unsigned CN  = NQ * K * L;
  localparam int unsigned HAW = $clog2(HN);
  localparam int unsigned CAW = $clog2(CN);
  localparam int unsigned QW  = $clog2(NQ);
  localparam int unsigned RW  = $clog2(M);
  localparam int unsigned CW  = $clog2(L);
  localparam int unsigned KW  = $clog2(K);

  localparam logic signed [AW-1:0] RND  = AW'(2 ** (Q - 1));
  localparam logic signed [AW-1:0] SMAX = AW'(2 ** (N - 1) - 1);
  localparam logic signed [AW-1:0] SMIN = ~SMAX;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOADH = 2'd1;
  localparam logic [1:0] ST_CALC  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]            r_state;
  logic [HAW-1:0]        r_hcnt;
  logic [KW-1:0]         r_k;
  logic [CW-1:0]         r_col;
  logic [RW-1:0]         r_row;
  logic [QW-1:0]         r_q;
  logic                  r_last_loaded;  // final element is in the output register
  logic signed [AW-1:0]  r_acc_r;
  logic signed [AW-1:0]  r_acc_i;
  logic                  r_y_valid;
  logic [N-1:0]          r_y_r;
  logic [N-1:0]          r_y_i;
  logic [QW-1:0]         r_y_q;
  logic [RW-1:0]         r_y_row;
  logic [CW-1:0]         r_y_col;
  logic                  r_sat;

  // Storage without reset: contents survive rst and state changes.
  logic [N-1:0] r_hmem_r  [HN];
  logic [N-1:0] r_hmem_i  [HN];
  logic [N-1:0] r_cbmem_r [CN];
  logic [N-1:0] r_cbmem_i [CN];

  logic                  w_en;
  logic                  w_xfer;
  logic                  w_calc;
  logic                  w_k_last;
  logic                  w_is_last;
  logic [HAW-1:0]        w_h_idx;
  logic [CAW-1:0]        w_cb_idx;
  logic signed [N-1:0]   w_ar;
  logic signed [N-1:0]   w_ai;
  logic signed [N-1:0]   w_br;
  logic signed [N-1:0]   w_bi;
  logic signed [2*N-1:0] w_prr;
  logic signed [2*N-1:0] w_pii;
  logic signed [2*N-1:0] w_pri;
  logic signed [2*N-1:0] w_pir;
  logic signed [AW-1:0]  w_base_r;
  logic signed [AW-1:0]  w_base_i;
  logic signed [AW-1:0]  w_acc_nr;
  logic signed [AW-1:0]  w_acc_ni;
  logic signed [AW-1:0]  w_rnd_r;
  logic signed [AW-1:0]  w_rnd_i;
  logic [N-1:0]          w_y_nr;
  logic [N-1:0]          w_y_ni;
  logic                  w_sat_any;

  assign w_en      = !r_y_valid || y_ready;
  assign w_xfer    = r_y_valid && y_ready;
  // After the final element is loaded, compute stops until it is transferred.
  assign w_calc    = (r_state == ST_CALC) && w_en && !r_last_loaded;
  assign w_k_last  = (r_k == KW'(K - 1));
  assign w_is_last = (r_q == QW'(NQ - 1)) && (r_row == RW'(M - 1)) && (r_col == CW'(L - 1));

  assign w_h_idx  = HAW'(int'(r_row) * K + int'(r_k));
  assign w_cb_idx = CAW'(int'(r_q) * K * L + int'(r_k) * L + int'(r_col));

  assign w_ar = r_hmem_r[w_h_idx];
  assign w_ai = r_hmem_i[w_h_idx];
  assign w_br = r_cbmem_r[w_cb_idx];
  assign w_bi = r_cbmem_i[w_cb_idx];

  assign w_prr = w_ar * w_br;
  assign w_pii = w_ai * w_bi;
  assign w_pri = w_ar * w_bi;
  assign w_pir = w_ai * w_br;

  always_comb begin
    w_base_r  = (r_k == '0) ? AW'(0) : r_acc_r;
    w_base_i  = (r_k == '0) ? AW'(0) : r_acc_i;
    w_acc_nr  = w_base_r + AW'(w_prr) - AW'(w_pii);
    w_acc_ni  = w_base_i + AW'(w_pri) + AW'(w_pir);
    w_rnd_r   = (w_acc_nr + RND) >>> Q;
    w_rnd_i   = (w_acc_ni + RND) >>> Q;
    w_sat_any = 1'b0;
    w_y_nr    = w_rnd_r[N-1:0];
    w_y_ni    = w_rnd_i[N-1:0];
    if (w_rnd_r > SMAX) begin
      w_y_nr    = SMAX[N-1:0];
      w_sat_any = 1'b1;
    end else if (w_rnd_r < SMIN) begin
      w_y_nr    = SMIN[N-1:0];
      w_sat_any = 1'b1;
    end
    if (w_rnd_i > SMAX) begin
      w_y_ni    = SMAX[N-1:0];
      w_sat_any = 1'b1;
    end else if (w_rnd_i < SMIN) begin
      w_y_ni    = SMIN[N-1:0];
      w_sat_any = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == ST_LOADH && h_valid) begin
      r_hmem_r[r_hcnt] <= h_r;
      r_hmem_i[r_hcnt] <= h_i;
    end
    if (cb_we && (r_state == ST_IDLE || r_state == ST_DONE)) begin
      r_cbmem_r[cb_addr] <= cb_r;
      r_cbmem_i[cb_addr] <= cb_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_hcnt        <= '0;
      r_k           <= '0;
      r_col         <= '0;
      r_row         <= '0;
      r_q           <= '0;
      r_last_loaded <= 1'b0;
      r_acc_r       <= '0;
      r_acc_i       <= '0;
      r_y_valid     <= 1'b0;
      r_y_r         <= '0;
      r_y_i         <= '0;
      r_y_q         <= '0;
      r_y_row       <= '0;
      r_y_col       <= '0;
      r_sat         <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_sat         <= 1'b0;
            r_hcnt        <= '0;
            r_k           <= '0;
            r_col         <= '0;
            r_row         <= '0;
            r_q           <= '0;
            r_last_loaded <= 1'b0;
            r_state       <= reuse_h ? ST_CALC : ST_LOADH;
          end
        end
        ST_LOADH: begin
          if (h_valid) begin
            r_hcnt <= r_hcnt + 1'b1;
            if (r_hcnt == HAW'(HN - 1)) begin
              r_state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (w_calc) begin
            r_acc_r <= w_acc_nr;
            r_acc_i <= w_acc_ni;
            if (w_k_last) begin
              r_k <= '0;
              if (w_is_last) begin
                r_last_loaded <= 1'b1;
              end
              if (r_col == CW'(L - 1)) begin
                r_col <= '0;
                if (r_row == RW'(M - 1)) begin
                  r_row <= '0;
                  r_q   <= r_q + 1'b1;
                end else begin
                  r_row <= r_row + 1'b1;
                end
              end else begin
                r_col <= r_col + 1'b1;
              end
            end else begin
              r_k <= r_k + 1'b1;
            end
          end
          if (r_last_loaded && w_xfer) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase

      // Output register: a new result may load on the same edge as a transfer.
      if (w_calc && w_k_last) begin
        r_y_valid <= 1'b1;
        r_y_r     <= w_y_nr;
        r_y_i     <= w_y_ni;
        r_y_q     <= r_q;
        r_y_row   <= r_row;
        r_y_col   <= r_col;
        if (w_sat_any) begin
          r_sat <= 1'b1;
        end
      end else if (w_xfer) begin
        r_y_valid <= 1'b0;
      end
    end
  end

  assign h_ready  = (r_state == ST_LOADH);
  assign busy     = (r_state != ST_IDLE);
  assign done     = (r_state == ST_DONE);
  assign sat_flag = r_sat;
  assign y_valid  = r_y_valid;
  assign y_r      = r_y_r;
  assign y_i      = r_y_i;
  assign y_q      = r_y_q;
  assign y_row    = r_y_row;
  assign y_col    = r_y_col;

endmodule

// File: tb/tb_cword_mat_mult.sv
// Testbench for cword_mat_mult: scoreboard of expected results computed from a
// plain-arithmetic matrix model, checked by a monitor on every output transfer.
module tb_cword_mat_mult;

  localparam int M = 4, K = 4, L = 2, NQ = 16, N = 16, Q = 8;

  logic        clk = 1'b0;
  logic        rst, start, reuse_h, h_valid, h_ready;
  logic [15:0] h_r, h_i;
  logic        cb_we;
  logic [6:0]  cb_addr;
  logic [15:0] cb_r, cb_i;
  logic        y_valid, y_ready;
  logic [15:0] y_r, y_i;
  logic [3:0]  y_q;
  logic [1:0]  y_row;
  logic [0:0]  y_col;
  logic        busy, done, sat_flag;

  cword_mat_mult dut (
    .clk(clk), .rst(rst), .start(start), .reuse_h(reuse_h),
    .h_valid(h_valid), .h_ready(h_ready), .h_r(h_r), .h_i(h_i),
    .cb_we(cb_we), .cb_addr(cb_addr), .cb_r(cb_r), .cb_i(cb_i),
    .y_valid(y_valid), .y_ready(y_ready), .y_r(y_r), .y_i(y_i),
    .y_q(y_q), .y_row(y_row), .y_col(y_col),
    .busy(busy), .done(done), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    int r;
    int i;
    int q;
    int row;
    int col;
  } exp_t;

  exp_t sb[$];
  int   ncmp = 0, nerr = 0;
  int   done_cnt = 0, hready_seen = 0, nxfer = 0;
  int   hold_cnt = 0;
  bit   rnd_ready = 1'b0;

  // Reference model contents (signed values)
  int mh_r[M*K], mh_i[M*K];
  int ms_r[NQ*K*L], ms_i[NQ*K*L];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sx16(input int v);
    logic signed [15:0] t;
    t = 16'(v);
    return int'(t);
  endfunction

  // Y_q[row][col] = sum_k H[row][k] * S_q[k][col], rounded half up, clamped.
  function automatic void model_elem(input int q, input int row, input int col,
                                     output int yr, output int yi, output bit sat);
    longint acc_r = 0, acc_i = 0, rr, ri;
    for (int k = 0; k < K; k++) begin
      longint ar = mh_r[row*K+k], ai = mh_i[row*K+k];
      longint br = ms_r[q*K*L+k*L+col], bi = ms_i[q*K*L+k*L+col];
      acc_r += ar * br - ai * bi;
      acc_i += ar * bi + ai * br;
    end
    rr  = (acc_r + (longint'(1) << (Q - 1))) >>> Q;
    ri  = (acc_i + (longint'(1) << (Q - 1))) >>> Q;
    sat = 1'b0;
    if (rr > 32767)  begin rr = 32767;  sat = 1'b1; end
    if (rr < -32768) begin rr = -32768; sat = 1'b1; end
    if (ri > 32767)  begin ri = 32767;  sat = 1'b1; end
    if (ri < -32768) begin ri = -32768; sat = 1'b1; end
    yr = int'(rr);
    yi = int'(ri);
  endfunction

  function automatic bit push_expected();
    bit any = 1'b0;
    for (int q = 0; q < NQ; q++)
      for (int row = 0; row < M; row++)
        for (int col = 0; col < L; col++) begin
          int yr, yi;
          bit s;
          model_elem(q, row, col, yr, yi, s);
          sb.push_back('{yr, yi, q, row, col});
          any |= s;
        end
    return any;
  endfunction

  task automatic write_cb(input int a, input int r, input int i);
    cb_we = 1'b1; cb_addr = 7'(a); cb_r = 16'(r); cb_i = 16'(i);
    tick();
    cb_we = 1'b0;
    ms_r[a] = sx16(r);
    ms_i[a] = sx16(i);
  endtask

  task automatic set_h(input int idx, input int r, input int i);
    mh_r[idx] = sx16(r);
    mh_i[idx] = sx16(i);
  endtask

  task automatic run(input bit reuse, input string tag);
    bit se;
    int cyc;
    se = push_expected();
    done_cnt = 0;
    hready_seen = 0;
    start = 1'b1; reuse_h = reuse;
    tick();
    start = 1'b0; reuse_h = 1'b0;
    check({tag, "_busy_after_start"}, 64'(busy), 64'(1));
    check({tag, "_sat_cleared"}, 64'(sat_flag), 64'(0));
    if (!reuse) begin
      for (int idx = 0; idx < M*K; idx++) begin
        while ($urandom_range(0, 2) == 0) tick();
        h_valid = 1'b1; h_r = 16'(mh_r[idx]); h_i = 16'(mh_i[idx]);
        tick();
        h_valid = 1'b0;
      end
    end
    cyc = 0;
    while (done_cnt == 0 && cyc < 5000) begin
      tick();
      cyc++;
    end
    check({tag, "_done_seen"}, 64'(done_cnt != 0), 64'(1));
    repeat (3) tick();
    check({tag, "_done_once"}, 64'(done_cnt), 64'(1));
    check({tag, "_all_transferred"}, 64'(sb.size()), 64'(0));
    check({tag, "_sat_flag"}, 64'(sat_flag), 64'(se));
    check({tag, "_idle"}, 64'(busy), 64'(0));
    if (reuse) check({tag, "_no_h_ready"}, 64'(hready_seen), 64'(0));
    sb.delete();
  endtask

  // Ready driver: optional forced hold, else always or randomly ready.
  always @(posedge clk) begin
    #1;
    if (hold_cnt > 0) begin
      y_ready = 1'b0;
      hold_cnt--;
    end else begin
      y_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Monitor: sample mid-cycle; a transfer happens on the next rising edge.
  logic [38:0] held;
  bit          hold_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (h_ready) hready_seen++;
      if (hold_prev) begin
        check("stall_stable", {24'(0), y_valid, y_r, y_i, y_q, y_row, y_col},
              {24'(0), 1'b1, held});
      end
      hold_prev = y_valid && !y_ready;
      held = {y_r, y_i, y_q, y_row, y_col};
      if (y_valid && y_ready) begin
        nxfer++;
        if (sb.size() == 0) begin
          check("unexpected_output", 64'(1), 64'(0));
        end else begin
          e = sb.pop_front();
          check("result", {25'(0), y_r, y_i, y_q, y_row, y_col},
                {25'(0), 16'(e.r), 16'(e.i), 4'(e.q), 2'(e.row), 1'(e.col)});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    rst = 1'b1; start = 1'b0; reuse_h = 1'b0; h_valid = 1'b0; h_r = '0; h_i = '0;
    cb_we = 1'b0; cb_addr = '0; cb_r = '0; cb_i = '0; y_ready = 1'b1;
    repeat (3) tick();
    check("rst_ctrl", 64'({h_ready, y_valid, done, busy, sat_flag}), 64'(0));
    check("rst_data", 64'({y_r, y_i, y_q, y_row, y_col}), 64'(0));
    rst = 1'b0;
    tick();

    // Identity H, all S entries 0.5
    for (int a = 0; a < NQ*K*L; a++) write_cb(a, 'h0080, 0);
    for (int idx = 0; idx < M*K; idx++) set_h(idx, (idx / K == idx % K) ? 'h0100 : 0, 0);
    run(1'b0, "identity");

    // Complex product (1+j) * (0.5j) = -0.5 + 0.5j in Y_0[0][0]
    for (int a = 0; a < NQ*K*L; a++) write_cb(a, (a == 0) ? 0 : 0, (a == 0) ? 'h0080 : 0);
    for (int idx = 0; idx < M*K; idx++) set_h(idx, (idx == 0) ? 'h0100 : 0, (idx == 0) ? 'h0100 : 0);
    run(1'b0, "complex");

    // Saturation, then stickiness while idle
    for (int a = 0; a < NQ*K*L; a++) write_cb(a, 'h7FFF, 0);
    for (int idx = 0; idx < M*K; idx++) set_h(idx, 'h7FFF, 0);
    run(1'b0, "saturate");
    repeat (5) tick();
    check("sat_sticky", 64'(sat_flag), 64'(1));

    // Random data, random ready, plus a forced 10-cycle stall
    for (int a = 0; a < NQ*K*L; a++)
      write_cb(a, int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048);
    for (int idx = 0; idx < M*K; idx++)
      set_h(idx, int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048);
    rnd_ready = 1'b1;
    fork
      run(1'b0, "random");
      begin
        int c = 0;
        while (!y_valid && c < 2000) begin tick(); c++; end
        hold_cnt = 10;
      end
    join

    // Reuse stored H
    run(1'b1, "reuse");

    // Abort mid-run with ignored codebook writes during CALC
    void'(push_expected());
    done_cnt = 0;
    base = nxfer;
    start = 1'b1; reuse_h = 1'b1;
    tick();
    start = 1'b0; reuse_h = 1'b0;
    for (int c = 0; c < 2000 && nxfer < base + 5; c++) tick();
    for (int j = 0; j < 8; j++) begin
      cb_we = 1'b1; cb_addr = 7'($urandom_range(0, 127));
      cb_r = 16'($urandom); cb_i = 16'($urandom);
      tick();
    end
    cb_we = 1'b0;
    check("abort_in_calc", 64'(busy), 64'(1));
    rst = 1'b1;
    tick();
    check("abort_y_valid", 64'(y_valid), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    rst = 1'b0;
    sb.delete();
    repeat (10) tick();
    check("abort_no_done", 64'(done_cnt), 64'(0));
    check("abort_no_output", 64'(y_valid), 64'(0));

    // Retained H and unmodified codebook after reset
    run(1'b1, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/cword_mat_mult.md
CWORD_MAT_MULT -- requirements
Module: cword_mat_mult

Interface
REQ-001 SHALL have parameters (name, default, meaning): Q, 8, fractional bits of all data words.
REQ-002 SHALL have parameter N, 16, signed word width of each real/imag part.
REQ-003 SHALL have parameters M, 4, H rows; K, 4, H columns = codeword rows; L, 2, codeword columns; NQ, 16, codewords.
REQ-004 SHALL have ports (name, direction, width, meaning): clk in 1 clock; rst in 1 reset. Reset rst is asynchronous, active-high; the clock is clk.
REQ-005 SHALL have ports start in 1 begins a run; reuse_h in 1 sampled with start, skips H load.
REQ-006 SHALL have ports h_valid in 1; h_ready out 1; h_r, h_i in N; H element stream, row-major.
REQ-007 SHALL have ports cb_we in 1; cb_addr in clog2(NQ*K*L); cb_r, cb_i in N; codebook write, address q*K*L+k*L+l.
REQ-008 SHALL have ports y_valid out 1; y_ready in 1; y_r, y_i out N; y_q out clog2(NQ); y_row out clog2(M); y_col out clog2(L); result stream.
REQ-009 SHALL have ports busy out 1 (state not IDLE); done out 1 (one-cycle pulse); sat_flag out 1 (sticky saturation).

Function
REQ-010 SHALL compute Y_q = H x S_q for q = 0..NQ-1; H is M x K complex, S_q is K x L complex from the codebook RAM.
REQ-011 SHALL implement states IDLE, LOAD_H, CALC, DONE.
REQ-012 IDLE: start=1 with reuse_h=0 -> LOAD_H; start=1 with reuse_h=1 -> CALC, using the stored H.
REQ-013 LOAD_H: h_ready=1; each h_valid beat stores to H[row][col] in row-major order; after the M*K-th beat -> CALC.
REQ-014 CALC: one complex MAC term per enabled cycle, k = 0..K-1.
REQ-015 CALC output order: column l fastest, then row, then q (q slowest).
REQ-016 DONE: done=1 for exactly one cycle, then -> IDLE.
REQ-017 start SHALL be ignored outside IDLE.
REQ-018 cb_we SHALL write only in IDLE or DONE; writes in other states are ignored.
REQ-019 Complex multiply SHALL be re = ar*br - ai*bi, im = ar*bi + ai*br, using full 2N-bit products.
REQ-020 The accumulator SHALL be 2N+clog2(K)+1 bits and SHALL clear at k=0.
REQ-021 Result SHALL be (acc + 2^(Q-1)) >>> Q (round half up), then saturated to [-2^(N-1), 2^(N-1)-1].
REQ-022 Any saturation in re or im SHALL set sat_flag; sat_flag is cleared only by rst or by an accepted start.
REQ-023 The result SHALL load into the output register on the clock edge after the k=K-1 term, with y_valid=1 and y_q/y_row/y_col tagged.
REQ-024 Compute enable = !y_valid || y_ready; while disabled, all counters and the accumulator hold.
REQ-025 y_* SHALL stay stable while y_valid=1 and y_ready=0.
REQ-026 Transfer SHALL occur when y_valid && y_ready; y_valid drops unless a new result loads on the same edge.
REQ-027 Throughput SHALL be one element per K cycles under continuous y_ready=1.
REQ-028 Transition CALC -> DONE SHALL occur on the edge that transfers the final element (q=NQ-1, row=M-1, col=L-1).
REQ-029 H and codebook storage SHALL be unaffected by state changes; stored H is retained across runs.

Reset
REQ-030 On rst: state=IDLE; h_ready, y_valid, done, busy, sat_flag = 0; y_r, y_i, y_q, y_row, y_col = 0; counters = 0.
REQ-031 rst SHALL NOT clear the H buffer or codebook RAM; a run with reuse_h=1 after rst uses the retained contents.
REQ-032 rst asserted mid-run SHALL abort immediately, with no further y_valid or done.

Verification
REQ-033 Identity: H = I (diag 0x0100, else 0); all S_q entries (0x0080, 0) -> 128 outputs; rows 0..3 all give y_r=0x0080, y_i=0; done pulses once; sat_flag=0.
REQ-034 Complex: H[0][0]=(0x0100,0x0100), rest of H 0; S_0[0][0]=(0,0x0080) -> Y_0[0][0] = (0xFF80, 0x0080).
REQ-035 Saturation: all H entries (0x7FFF,0) and all S entries (0x7FFF,0) -> every y_r=0x7FFF, y_i=0; sat_flag=1 and sticky until the next start.
REQ-036 Backpressure: hold y_ready=0 for 10 cycles while y_valid=1 -> y_* unchanged and no element lost; total transfers = NQ*M*L = 128.
REQ-037 Reuse: a second start with reuse_h=1 and no h_valid beats -> outputs identical to the first run; h_ready stays 0.
REQ-038 Abort and protect: rst pulse during CALC -> y_valid=0 and busy=0 next cycle; cb_we during CALC -> codebook unchanged, checked by the next run.
